// File: rtl/if_stage.sv
// Instruction fetch stage: drives a single-outstanding-request instruction memory
// port and loads the IF/ID pipeline register, honouring stalls, flushes and branch redirects.
module if_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        branch_matchD,
  input  logic [15:0] branch_targetD,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  output logic [15:0] instrD,
  output logic [15:0] pc_plus2D,
  output logic        validD,
  output logic        fetch_busy
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD, DRAIN} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] req_addr_q, req_addr_d;
  logic [15:0] hold_instr_q, hold_instr_d;
  logic [15:0] hold_pc2_q, hold_pc2_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc2_q, pc2_d;
  logic        valid_q, valid_d;
  logic        imem_req_q, imem_req_d;

  logic        deliver;
  logic [15:0] dl_instr;
  logic [15:0] dl_pc2;
  logic [15:0] req_plus2;

  assign req_plus2 = req_addr_q + 16'd2;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and infers a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    hold_instr_d = hold_instr_q;
    hold_pc2_d   = hold_pc2_q;
    deliver      = 1'b0;
    dl_instr     = 16'h0000;
    dl_pc2       = 16'h0000;

    case (state_q)
      IDLE: begin
        if (branch_matchD) begin
          pc_d = branch_targetD;
        end else if (!stallF) begin
          req_addr_d = pc_q;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          if (branch_matchD) begin
            pc_d       = branch_targetD;
            req_addr_d = branch_targetD;
          end else if (stallD) begin
            hold_instr_d = imem_data;
            hold_pc2_d   = req_plus2;
            pc_d         = req_plus2;
            state_d      = HOLD;
          end else begin
            deliver  = 1'b1;
            dl_instr = imem_data;
            dl_pc2   = req_plus2;
            pc_d     = req_plus2;
            if (!stallF) req_addr_d = req_plus2;
            else         state_d    = IDLE;
          end
        end else if (branch_matchD) begin
          // The in-flight response belongs to the wrong path; DRAIN swallows it.
          pc_d    = branch_targetD;
          state_d = DRAIN;
        end
      end
      HOLD: begin
        if (branch_matchD) begin
          pc_d    = branch_targetD;
          state_d = IDLE;
        end else if (!stallD) begin
          deliver  = 1'b1;
          dl_instr = hold_instr_q;
          dl_pc2   = hold_pc2_q;
          if (!stallF) begin
            req_addr_d = pc_q;
            state_d    = WAIT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        if (branch_matchD) pc_d = branch_targetD;
        if (imem_ack) begin
          req_addr_d = branch_matchD ? branch_targetD : pc_q;
          state_d    = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase

    // IF/ID: flush beats stall beats load; an advancing Decode with nothing
    // delivered this cycle takes a bubble so no instruction is issued twice.
    instr_d = instr_q;
    pc2_d   = pc2_q;
    valid_d = valid_q;
    if (flushD || (!stallD && !deliver)) begin
      instr_d = 16'h0000;
      pc2_d   = 16'h0000;
      valid_d = 1'b0;
    end else if (!stallD) begin
      instr_d = dl_instr;
      pc2_d   = dl_pc2;
      valid_d = 1'b1;
    end

    imem_req_d = (state_d == WAIT) || (state_d == DRAIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= 16'h0000;
      req_addr_q   <= 16'h0000;
      hold_instr_q <= 16'h0000;
      hold_pc2_q   <= 16'h0000;
      instr_q      <= 16'h0000;
      pc2_q        <= 16'h0000;
      valid_q      <= 1'b0;
      imem_req_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      hold_instr_q <= hold_instr_d;
      hold_pc2_q   <= hold_pc2_d;
      instr_q      <= instr_d;
      pc2_q        <= pc2_d;
      valid_q      <= valid_d;
      imem_req_q   <= imem_req_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = req_addr_q;
  assign instrD     = instr_q;
  assign pc_plus2D  = pc2_q;
  assign validD     = valid_q;
  assign fetch_busy = (state_q == WAIT) && !imem_ack;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed vector table, hand-written corner
// sequences, then randomized traffic against a transaction-level fetch model.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stallF, stallD, flushD, branch_matchD, imem_ack;
  logic [15:0] branch_targetD, imem_data;
  logic        imem_req, validD, fetch_busy;
  logic [15:0] imem_addr, instrD, pc_plus2D;

  int checks = 0;
  int errors = 0;

  if_stage dut (
    .clk(clk), .rst_n(rst_n), .stallF(stallF), .stallD(stallD), .flushD(flushD),
    .branch_matchD(branch_matchD), .branch_targetD(branch_targetD),
    .imem_ack(imem_ack), .imem_data(imem_data), .imem_req(imem_req),
    .imem_addr(imem_addr), .instrD(instrD), .pc_plus2D(pc_plus2D),
    .validD(validD), .fetch_busy(fetch_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sf, sd, fl, br;
    logic [15:0] tgt;
    logic        ack;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_busy, e_valid;
    logic [15:0] e_instr, e_pc2;
  } vec_t;

  // Reference model: one outstanding request, optionally marked to be thrown
  // away, plus an optional one-entry buffer for a response that Decode refused.
  logic        m_out, m_kill, m_buf;
  logic [15:0] m_pc, m_req, m_buf_i, m_buf_p2;
  logic [15:0] m_instr, m_pc2;
  logic        m_valid;

  task automatic model_reset();
    m_out = 0; m_kill = 0; m_buf = 0;
    m_pc = 0; m_req = 0; m_buf_i = 0; m_buf_p2 = 0;
    m_instr = 0; m_pc2 = 0; m_valid = 0;
  endtask

  task automatic model_step(input logic sf, input logic sd, input logic fl, input logic br,
                            input logic [15:0] tgt, input logic ack, input logic [15:0] data);
    logic        got;
    logic [15:0] gi, gp;
    got = 0; gi = 0; gp = 0;
    if (m_buf) begin
      if (br) begin
        m_pc = tgt; m_buf = 0;
      end else if (!sd) begin
        got = 1; gi = m_buf_i; gp = m_buf_p2; m_buf = 0;
        if (!sf) begin m_req = m_pc; m_out = 1; end
      end
    end else if (m_out && m_kill) begin
      if (br) m_pc = tgt;
      if (ack) begin m_req = m_pc; m_kill = 0; end
    end else if (m_out) begin
      if (ack && br) begin
        m_pc = tgt; m_req = tgt;
      end else if (ack && sd) begin
        m_buf = 1; m_buf_i = data; m_buf_p2 = 16'(m_req + 2); m_pc = m_buf_p2; m_out = 0;
      end else if (ack) begin
        got = 1; gi = data; gp = 16'(m_req + 2); m_pc = gp;
        if (!sf) m_req = gp; else m_out = 0;
      end else if (br) begin
        m_pc = tgt; m_kill = 1;
      end
    end else begin
      if (br) m_pc = tgt;
      else if (!sf) begin m_req = m_pc; m_out = 1; end
    end
    if (fl || (!sd && !got)) begin
      m_instr = 0; m_pc2 = 0; m_valid = 0;
    end else if (!sd) begin
      m_instr = gi; m_pc2 = gp; m_valid = 1;
    end
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_req, input logic [15:0] e_addr,
                            input logic e_busy, input logic e_valid,
                            input logic [15:0] e_instr, input logic [15:0] e_pc2);
    check({tag, ".imem_req"},   16'(imem_req),   16'(e_req));
    check({tag, ".imem_addr"},  imem_addr,       e_addr);
    check({tag, ".fetch_busy"}, 16'(fetch_busy), 16'(e_busy));
    check({tag, ".validD"},     16'(validD),     16'(e_valid));
    check({tag, ".instrD"},     instrD,          e_instr);
    check({tag, ".pc_plus2D"},  pc_plus2D,       e_pc2);
  endtask

  task automatic apply(input logic sf, input logic sd, input logic fl, input logic br,
                       input logic [15:0] tgt, input logic ack, input logic [15:0] data);
    stallF = sf; stallD = sd; flushD = fl; branch_matchD = br;
    branch_targetD = tgt; imem_ack = ack; imem_data = data;
  endtask

  // One model-checked cycle: drive while clk is low, compare, clock, advance model.
  task automatic step(input string tag, input logic sf, input logic sd, input logic fl,
                      input logic br, input logic [15:0] tgt, input logic ack,
                      input logic [15:0] data);
    apply(sf, sd, fl, br, tgt, ack, data);
    #1;
    check_outs(tag, m_out, m_req, m_out && !m_kill && !ack, m_valid, m_instr, m_pc2);
    @(posedge clk);
    model_step(sf, sd, fl, br, tgt, ack, data);
    @(negedge clk);
  endtask

  function automatic vec_t mkv(input logic sf, input logic sd, input logic fl, input logic br,
                               input logic [15:0] tgt, input logic ack, input logic e_req,
                               input logic [15:0] e_addr, input logic e_busy,
                               input logic e_valid, input logic [15:0] e_instr,
                               input logic [15:0] e_pc2);
    vec_t v;
    v.sf = sf; v.sd = sd; v.fl = fl; v.br = br; v.tgt = tgt; v.ack = ack;
    v.e_req = e_req; v.e_addr = e_addr; v.e_busy = e_busy; v.e_valid = e_valid;
    v.e_instr = e_instr; v.e_pc2 = e_pc2;
    return v;
  endfunction

  vec_t vecs[16];

  initial begin
    logic [15:0] d;
    // Memory contents for the directed table: word at address a is a + 0x1000.
    vecs[0]  = mkv(0,0,0,0,16'h0000,0, 0,16'h0000,0,0,16'h0000,16'h0000);
    vecs[1]  = mkv(0,0,0,0,16'h0000,1, 1,16'h0000,0,0,16'h0000,16'h0000);
    vecs[2]  = mkv(0,0,0,0,16'h0000,1, 1,16'h0002,0,1,16'h1000,16'h0002);
    vecs[3]  = mkv(0,0,0,0,16'h0000,0, 1,16'h0004,1,1,16'h1002,16'h0004);
    vecs[4]  = mkv(0,0,0,0,16'h0000,0, 1,16'h0004,1,0,16'h0000,16'h0000);
    vecs[5]  = mkv(0,0,0,0,16'h0000,0, 1,16'h0004,1,0,16'h0000,16'h0000);
    vecs[6]  = mkv(0,0,0,0,16'h0000,1, 1,16'h0004,0,0,16'h0000,16'h0000);
    vecs[7]  = mkv(0,1,0,0,16'h0000,1, 1,16'h0006,0,1,16'h1004,16'h0006);
    vecs[8]  = mkv(0,1,0,0,16'h0000,0, 0,16'h0006,0,1,16'h1004,16'h0006);
    vecs[9]  = mkv(0,0,0,0,16'h0000,0, 0,16'h0006,0,1,16'h1004,16'h0006);
    vecs[10] = mkv(0,0,0,0,16'h0000,1, 1,16'h0008,0,1,16'h1006,16'h0008);
    vecs[11] = mkv(0,0,1,1,16'h0040,0, 1,16'h000A,1,1,16'h1008,16'h000A);
    vecs[12] = mkv(0,0,0,0,16'h0000,0, 1,16'h000A,0,0,16'h0000,16'h0000);
    vecs[13] = mkv(0,0,0,0,16'h0000,1, 1,16'h000A,0,0,16'h0000,16'h0000);
    vecs[14] = mkv(0,0,0,0,16'h0000,1, 1,16'h0040,0,0,16'h0000,16'h0000);
    vecs[15] = mkv(0,0,0,0,16'h0000,0, 1,16'h0042,1,1,16'h1040,16'h0042);

    rst_n = 1'b0;
    apply(0, 0, 0, 0, 16'h0000, 0, 16'h0000);
    model_reset();
    #1;
    check_outs("reset", 0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      d = vecs[i].e_addr + 16'h1000;
      apply(vecs[i].sf, vecs[i].sd, vecs[i].fl, vecs[i].br, vecs[i].tgt, vecs[i].ack, d);
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_busy,
                 vecs[i].e_valid, vecs[i].e_instr, vecs[i].e_pc2);
      @(posedge clk);
      model_step(vecs[i].sf, vecs[i].sd, vecs[i].fl, vecs[i].br, vecs[i].tgt, vecs[i].ack, d);
      @(negedge clk);
    end

    // Reset asserted while a request is outstanding: outputs drop without a clock edge.
    check("pre_reset.imem_req", 16'(imem_req), 16'h0001);
    apply(0, 0, 0, 0, 16'h0000, 0, 16'h0000);
    rst_n = 1'b0;
    #1;
    check("async_rst.imem_req",   16'(imem_req),   16'h0000);
    check("async_rst.validD",     16'(validD),     16'h0000);
    check("async_rst.instrD",     instrD,          16'h0000);
    check("async_rst.imem_addr",  imem_addr,       16'h0000);
    check("async_rst.fetch_busy", 16'(fetch_busy), 16'h0000);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // First request after reset goes to 0000, then redirect to FFFE and wrap.
    step("post_rst", 0, 0, 0, 0, 16'h0000, 0, 16'h0000);
    check("post_rst.first_addr", imem_addr, 16'h0000);
    step("redir", 0, 0, 0, 1, 16'hFFFE, 1, 16'h1111);
    check("redir.addr", imem_addr, 16'hFFFE);
    step("wrap", 0, 0, 0, 0, 16'h0000, 1, 16'hABCD);
    check("wrap.pc_plus2D", pc_plus2D,  16'h0000);
    check("wrap.instrD",    instrD,     16'hABCD);
    check("wrap.imem_addr", imem_addr,  16'h0000);
    check("wrap.validD",    16'(validD), 16'h0001);

    // flushD together with stallD must still produce a bubble.
    step("flush_stall", 0, 1, 1, 0, 16'h0000, 0, 16'h0000);
    check("flush_stall.validD", 16'(validD), 16'h0000);

    for (int n = 0; n < 600; n++) begin
      logic [15:0] tgt;
      tgt = 16'($urandom) & 16'hFFFE;
      if ($urandom_range(0, 7) == 0) tgt = 16'hFFFC + 16'(2 * $urandom_range(0, 1));
      step($sformatf("rand%0d", n),
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
           tgt, $urandom_range(0, 1) == 1, 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named as the codebase does: clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 stallF  input  1  from hazard unit; blocks issue of a new fetch request.
REQ-005 stallD  input  1  from hazard unit; holds the IF/ID register.
REQ-006 flushD  input  1  from hazard unit; replaces the IF/ID contents with a bubble.
REQ-007 branch_matchD  input  1  taken branch resolved in Decode.
REQ-008 branch_targetD  input  16  redirect PC, valid when branch_matchD=1.
REQ-009 imem_ack  input  1  instruction memory returns data for the outstanding request.
REQ-010 imem_data  input  16  instruction word, valid with imem_ack.
REQ-011 imem_req  output  1  request outstanding to instruction memory.
REQ-012 imem_addr  output  16  address of the outstanding request.
REQ-013 instrD  output  16  IF/ID instruction register.
REQ-014 pc_plus2D  output  16  IF/ID register: fetch address + 2 of instrD.
REQ-015 validD  output  1  IF/ID holds a real instruction (0 = bubble).
REQ-016 fetch_busy  output  1  high when the block is in WAIT with imem_ack=0 (memory stall indicator).

Function
REQ-017 The block SHALL implement a four-state FSM: IDLE, WAIT, HOLD, DRAIN.
REQ-018 Registers SHALL be: pc (next fetch address), req_addr (address of outstanding request, drives imem_addr), hold_instr, hold_pc2, and the IF/ID registers.
REQ-019 imem_req SHALL be 1 exactly in WAIT and DRAIN; imem_addr=req_addr at all times, held stable until imem_ack.
REQ-020 IDLE: if branch_matchD, pc<=branch_targetD and stay IDLE; else if stallF=0, req_addr<=pc and go to WAIT; else stay IDLE.
REQ-021 WAIT with imem_ack=1 and branch_matchD=0, stallD=0: IF/ID<={imem_data, req_addr+2, valid=1}; pc<=req_addr+2; if stallF=0, req_addr<=req_addr+2 and stay WAIT (one instruction per cycle); else go to IDLE.
REQ-022 WAIT with imem_ack=1, branch_matchD=0, stallD=1: hold_instr<=imem_data, hold_pc2<=req_addr+2, pc<=req_addr+2, go to HOLD; IF/ID unchanged.
REQ-023 WAIT with imem_ack=1 and branch_matchD=1: returned data discarded; pc<=branch_targetD, req_addr<=branch_targetD, stay WAIT.
REQ-024 WAIT with imem_ack=0 and branch_matchD=1: pc<=branch_targetD, go to DRAIN (req_addr unchanged).
REQ-025 WAIT with imem_ack=0, branch_matchD=0: stay WAIT; if stallD=0, IF/ID<=bubble.
REQ-026 HOLD: imem_req=0; if branch_matchD, pc<=branch_targetD, buffer discarded, go to IDLE; else if stallD=0, IF/ID<={hold_instr, hold_pc2, 1}, then go to WAIT with req_addr<=pc if stallF=0, else IDLE.
REQ-027 DRAIN: wait for imem_ack; on ack, data discarded, req_addr<=pc, go to WAIT; a further branch_matchD in DRAIN SHALL update pc<=branch_targetD (last target wins).
REQ-028 Bubble SHALL be instrD=16'h0000, pc_plus2D=16'h0000, validD=0.
REQ-029 IF/ID priority per cycle: flushD (bubble) > stallD (hold) > load per REQ-021/025/026; flushD=1 with stallD=1 SHALL produce a bubble.
REQ-030 All PC arithmetic SHALL be 16-bit modulo; 16'hFFFE+2 wraps to 16'h0000.

Reset
REQ-031 On rst_n=0, immediately and regardless of clk: state=IDLE, pc=16'h0000, req_addr=16'h0000, hold registers=0, IF/ID=bubble, imem_req=0, fetch_busy=0.
REQ-032 Reset asserted mid-request SHALL abandon the request; the first request after release SHALL be to address 16'h0000.

Verification
REQ-033 Reset release, zero-wait memory (ack same cycle as req), stalls 0 -> imem_addr 0000,0002,0004 on consecutive cycles; instrD follows one cycle later, validD=1.
REQ-034 Memory ack delayed 3 cycles at address 0004 -> fetch_busy=1 for 3 cycles, validD=0 bubbles, then instruction at 0004 with pc_plus2D=0006.
REQ-035 stallD=1 for 2 cycles while ack arrives at 0006 -> HOLD entered, IF/ID unchanged, imem_req=0; on stallD=0, instrD=data@0006, pc_plus2D=0008, next request 0008.
REQ-036 branch_matchD=1, branch_targetD=0040 during a pending (unacked) request at 000A -> DRAIN, imem_addr stays 000A until ack, data discarded, next request 0040; flushD=1 gives validD=0.
REQ-037 pc=FFFE, normal fetch -> pc_plus2D=0000 and next imem_addr=0000; assert rst_n=0 during WAIT -> imem_req drops asynchronously, IF/ID bubble.
